// File: rtl/fifo_pop_arbiter.sv
// fifo_pop_arbiter: five-way pop arbiter feeding a single registered output stream.
// Picks at most one non-empty FIFO per cycle, strobes its pop combinationally and
// registers the popped word one cycle later. IDLE tells downstream counters when
// the arbiter has nothing in flight.
//
// Optional feature: define ROUND_ROBIN_EN for round-robin arbitration (pointer
// holds the last granted index). Undefined builds use fixed lowest-index priority.
//
// Ports:
//   CLK, reset              clock, asynchronous active-high reset
//   empty0..4               input FIFO empty flags (1 = no data)
//   data_in0..4             head-of-FIFO words, valid when matching pop is high
//   stall                   downstream almost-full, blocks all pops
//   pop0..4                 combinational pop strobes, at most one high
//   data_out, grant_idx     registered popped word and its source index
//   valid_out               registered, word popped in the previous cycle
//   IDLE                    registered, arbiter in IDLE state
module fifo_pop_arbiter #(
  parameter int unsigned DATA_W = 6
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              empty0,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  input  logic              empty4,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [DATA_W-1:0] data_in4,
  input  logic              stall,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  output logic              pop4,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [2:0]        grant_idx,
  output logic              IDLE
);

  localparam int unsigned N_FIFO = 5;
  localparam int unsigned IDX_W  = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               idle_q, idle_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [IDX_W-1:0]   grant_q, grant_d;

  logic [N_FIFO-1:0]  empty_v;
  logic [N_FIFO-1:0]  pop_v;
  logic [DATA_W-1:0]  din [N_FIFO];
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_vld;

  assign empty_v = {empty4, empty3, empty2, empty1, empty0};
  assign din[0]  = data_in0;
  assign din[1]  = data_in1;
  assign din[2]  = data_in2;
  assign din[3]  = data_in3;
  assign din[4]  = data_in4;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Round-robin search starting one past the last grant, wrapping 4 -> 0.
  always_comb begin : rr_select
    int unsigned cand;
    cand    = 0;
    sel_idx = '0;
    sel_vld = 1'b0;
    for (int unsigned k = 1; k <= N_FIFO; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= N_FIFO) cand = cand - N_FIFO;
      if (!sel_vld && !empty_v[IDX_W'(cand)]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(cand);
      end
    end
  end

  // Pointer advances only when a pop is actually issued.
  always_comb begin : rr_ptr_next
    ptr_d = ptr_q;
    if (|pop_v) ptr_d = sel_idx;
  end

  always_ff @(posedge CLK or posedge reset) begin : rr_ptr_reg
    if (reset) ptr_q <= IDX_W'(4);
    else       ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest non-empty index wins.
  always_comb begin : fixed_select
    sel_idx = '0;
    sel_vld = 1'b0;
    for (int unsigned i = 0; i < N_FIFO; i++) begin
      if (!sel_vld && !empty_v[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end
`endif

  // Next state, pop strobes and output register inputs.
  always_comb begin : fsm_next
    state_d = state_q;
    pop_v   = '0;
    valid_d = 1'b0;
    data_d  = data_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (!(&empty_v)) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (&empty_v) state_d = ST_IDLE;
        if (!stall && sel_vld) begin
          pop_v[sel_idx] = 1'b1;
          valid_d        = 1'b1;
          data_d         = din[sel_idx];
          grant_d        = sel_idx;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or posedge reset) begin : state_regs
    if (reset) begin
      state_q <= ST_IDLE;
      idle_q  <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign pop0      = pop_v[0];
  assign pop1      = pop_v[1];
  assign pop2      = pop_v[2];
  assign pop3      = pop_v[3];
  assign pop4      = pop_v[4];
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign grant_idx = grant_q;
  assign IDLE      = idle_q;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Testbench for fifo_pop_arbiter: directed vector table, hand sequences for
// stall / mid-burst reset, and a randomized run with queued FIFO contents
// checked against a behavioural reference model.
module tb_fifo_pop_arbiter;

  logic       CLK;
  logic       reset;
  logic       stall;
  logic [4:0] empty_v;
  logic [5:0] din [5];
  logic       pop0, pop1, pop2, pop3, pop4;
  logic [5:0] data_out;
  logic       valid_out;
  logic [2:0] grant_idx;
  logic       IDLE;
  logic [4:0] pop_v;

  assign pop_v = {pop4, pop3, pop2, pop1, pop0};

  fifo_pop_arbiter #(.DATA_W(6)) dut (
    .CLK(CLK), .reset(reset),
    .empty0(empty_v[0]), .empty1(empty_v[1]), .empty2(empty_v[2]),
    .empty3(empty_v[3]), .empty4(empty_v[4]),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]),
    .data_in3(din[3]), .data_in4(din[4]),
    .stall(stall),
    .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3), .pop4(pop4),
    .data_out(data_out), .valid_out(valid_out), .grant_idx(grant_idx), .IDLE(IDLE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit         m_active;
  int         m_ptr;
  logic [5:0] e_data;
  logic [2:0] e_grant;
  bit         e_valid;
  bit         e_idle;
  int         dut_pops [5];

  typedef struct {
    logic [4:0] emp;
    logic       stl;
    logic [5:0] d;
    logic [4:0] xpop;
    logic       xvalid;
    logic [5:0] xdata;
    logic [2:0] xgrant;
    logic       xidle;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_ptr    = 4;
    e_data   = '0;
    e_grant  = '0;
    e_valid  = 1'b0;
    e_idle   = 1'b1;
  endtask

  // Which FIFO should be popped this cycle, -1 for none.
  function automatic int pick();
    if (!m_active || stall) return -1;
`ifdef ROUND_ROBIN_EN
    for (int k = 1; k <= 5; k++) begin
      int i;
      i = (m_ptr + k) % 5;
      if (!empty_v[i]) return i;
    end
`else
    for (int i = 0; i < 5; i++) begin
      if (!empty_v[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Called just after a rising edge with inputs already driven.
  task automatic step(input string tag, output int got, output logic [4:0] seen);
    int         idx;
    logic [4:0] exp_pop;
    #1;
    idx     = pick();
    exp_pop = (idx >= 0) ? 5'(1 << idx) : 5'd0;
    seen    = pop_v;
    chk({tag, " pop"}, 32'(pop_v), 32'(exp_pop));
    for (int i = 0; i < 5; i++) if (pop_v[i]) dut_pops[i]++;
    @(posedge CLK);
    if (idx >= 0) begin
      e_data  = din[idx];
      e_grant = 3'(idx);
      e_valid = 1'b1;
      m_ptr   = idx;
    end else begin
      e_valid = 1'b0;
    end
    m_active = (empty_v != 5'h1f);
    e_idle   = !m_active;
    #1;
    chk({tag, " valid"}, 32'(valid_out), 32'(e_valid));
    chk({tag, " data"},  32'(data_out),  32'(e_data));
    chk({tag, " grant"}, 32'(grant_idx), 32'(e_grant));
    chk({tag, " idle"},  32'(IDLE),      32'(e_idle));
    got = idx;
  endtask

  // Asynchronous reset pulse starting between edges; returns just after an edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst pop",   32'(pop_v),     32'd0);
    chk("rst valid", 32'(valid_out), 32'd0);
    chk("rst idle",  32'(IDLE),      32'd1);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) dut_pops[i] = 0;
  endtask

  initial begin
    int         idx;
    logic [4:0] ps;
    int         exp_i;
    logic [5:0] fbuf [5][256];
    int         rd [5];
    int         wr [5];
    int         occ [5];
    int         supplied [5];

    tbl[0]  = '{5'h1f, 1'b0, 6'h00, 5'h00, 1'b0, 6'h00, 3'd0, 1'b1};
    tbl[1]  = '{5'h1b, 1'b0, 6'h15, 5'h00, 1'b0, 6'h00, 3'd0, 1'b0};
    tbl[2]  = '{5'h1b, 1'b0, 6'h15, 5'h04, 1'b1, 6'h15, 3'd2, 1'b0};
    tbl[3]  = '{5'h1b, 1'b1, 6'h22, 5'h00, 1'b0, 6'h15, 3'd2, 1'b0};
    tbl[4]  = '{5'h0f, 1'b0, 6'h2a, 5'h10, 1'b1, 6'h2a, 3'd4, 1'b0};
    tbl[5]  = '{5'h1e, 1'b0, 6'h07, 5'h01, 1'b1, 6'h07, 3'd0, 1'b0};
    tbl[6]  = '{5'h1f, 1'b0, 6'h3f, 5'h00, 1'b0, 6'h07, 3'd0, 1'b1};
    tbl[7]  = '{5'h1f, 1'b0, 6'h3f, 5'h00, 1'b0, 6'h07, 3'd0, 1'b1};
    tbl[8]  = '{5'h17, 1'b0, 6'h33, 5'h00, 1'b0, 6'h07, 3'd0, 1'b0};
    tbl[9]  = '{5'h17, 1'b1, 6'h33, 5'h00, 1'b0, 6'h07, 3'd0, 1'b0};
    tbl[10] = '{5'h1f, 1'b0, 6'h11, 5'h00, 1'b0, 6'h07, 3'd0, 1'b1};

    // Reset held with every FIFO non-empty
    reset   = 1'b1;
    stall   = 1'b0;
    empty_v = 5'h00;
    for (int i = 0; i < 5; i++) din[i] = 6'h2d;
    #1;
    chk("init pop",   32'(pop_v),     32'd0);
    chk("init idle",  32'(IDLE),      32'd1);
    chk("init valid", 32'(valid_out), 32'd0);
    chk("init data",  32'(data_out),  32'd0);
    chk("init grant", 32'(grant_idx), 32'd0);
    @(posedge CLK);
    #1;
    chk("init held pop",  32'(pop_v), 32'd0);
    chk("init held idle", 32'(IDLE),  32'd1);
    empty_v = 5'h1f;
    reset   = 1'b0;
    model_reset();

    // Directed vector table
    for (int v = 0; v < 11; v++) begin
      empty_v = tbl[v].emp;
      stall   = tbl[v].stl;
      for (int i = 0; i < 5; i++) din[i] = tbl[v].d;
      step("tbl", idx, ps);
      chk("tbl xpop",   32'(ps),        32'(tbl[v].xpop));
      chk("tbl xvalid", 32'(valid_out), 32'(tbl[v].xvalid));
      chk("tbl xdata",  32'(data_out),  32'(tbl[v].xdata));
      chk("tbl xgrant", 32'(grant_idx), 32'(tbl[v].xgrant));
      chk("tbl xidle",  32'(IDLE),      32'(tbl[v].xidle));
    end

    // All FIFOs non-empty: grant order
    do_reset();
    empty_v = 5'h00;
    stall   = 1'b0;
    for (int i = 0; i < 5; i++) din[i] = 6'(8 * i + 3);
    step("all act", idx, ps);
    chk("all act nopop", 32'(ps), 32'd0);
    for (int k = 0; k < 10; k++) begin
`ifdef ROUND_ROBIN_EN
      exp_i = k % 5;
`else
      exp_i = 0;
`endif
      step("all", idx, ps);
      chk("all order", 32'(ps), 32'(5'(1 << exp_i)));
    end

    // Stall for three cycles mid-burst
    step("stl pre", idx, ps);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("stl", idx, ps);
      chk("stl nopop", 32'(ps), 32'd0);
    end
    stall = 1'b0;
    step("stl resume", idx, ps);
    chk("stl resume pop", 32'(|ps), 32'd1);

    // Asynchronous reset between edges during a burst
    step("mrst burst", idx, ps);
    #1;
    chk("mrst pre pop", 32'(|pop_v), 32'd1);
    reset = 1'b1;
    #1;
    chk("mrst pop",   32'(pop_v),     32'd0);
    chk("mrst valid", 32'(valid_out), 32'd0);
    chk("mrst idle",  32'(IDLE),      32'd1);
    chk("mrst data",  32'(data_out),  32'd0);
    chk("mrst grant", 32'(grant_idx), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    reset = 1'b0;
    step("mrst act", idx, ps);
    chk("mrst act nopop", 32'(ps), 32'd0);
    step("mrst first", idx, ps);
    chk("mrst first pop0", 32'(ps), 32'd1);
    chk("mrst first grant", 32'(grant_idx), 32'd0);

    // Randomized traffic with queued FIFO contents, then drain
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rd[i] = 0; wr[i] = 0; occ[i] = 0; supplied[i] = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (c < 1400 && occ[i] < 6 && $urandom_range(0, 3) == 0) begin
          fbuf[i][wr[i]] = 6'($urandom);
          wr[i] = (wr[i] + 1) % 256;
          occ[i]++;
          supplied[i]++;
        end
        empty_v[i] = (occ[i] == 0);
        din[i]     = (occ[i] != 0) ? fbuf[i][rd[i]] : 6'($urandom);
      end
      stall = ($urandom_range(0, 4) == 0);
      step("rnd", idx, ps);
      if (idx >= 0) begin
        rd[idx] = (rd[idx] + 1) % 256;
        occ[idx]--;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("drain empty", 32'(occ[i]), 32'd0);
      chk("drain count", 32'(dut_pops[i]), 32'(supplied[i]));
    end
    chk("drain idle",  32'(IDLE),      32'd1);
    chk("drain valid", 32'(valid_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_pop_arbiter.md
# fifo_pop_arbiter

Five-way pop arbiter that sits directly upstream of the pop counters block. Each cycle it selects at most one non-empty input FIFO, issues that FIFO's pop (pop0..pop4), and registers the popped word onto a single output stream with a valid flag. It also drives the IDLE indication the counters use to decide when their totals may be read. Downstream backpressure is honoured through a single stall input.

## Interface
- DATA_W, 6: width of each FIFO data word and of data_out.
- CLK  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- empty0..empty4  in  1 each  empty flag of input FIFO n; 1 = no data.
- data_in0..data_in4  in  DATA_W each  head-of-FIFO word of FIFO n, valid in the cycle popN is high.
- stall  in  1  downstream almost-full; 1 = no pop may be issued this cycle.
- pop0..pop4  out  1 each  combinational pop strobe to FIFO n; at most one high per cycle.
- data_out  out  DATA_W  registered popped word.
- valid_out  out  1  registered; 1 = data_out holds a word popped in the previous cycle.
- grant_idx  out  3  registered index (0..4) of the FIFO that produced data_out.
- IDLE  out  1  registered; 1 = arbiter in IDLE state.

## Operation
- FSM, two states: IDLE, ACTIVE. Reset state IDLE.
- IDLE -> ACTIVE when any emptyN == 0 at the clock edge. No pops are issued while in IDLE.
- ACTIVE -> IDLE when all emptyN == 1 at the clock edge; stall does not affect transitions.
- In ACTIVE with stall == 0: exactly one popN asserted for the selected non-empty FIFO; none if all empty.
- In ACTIVE with stall == 1: all popN == 0.
- Selection with arbitration per Configuration; a FIFO with emptyN == 1 is never popped.
- On edge where popN was high: data_out <= data_inN, grant_idx <= N, valid_out <= 1.
- On edge with no pop: valid_out <= 0; data_out and grant_idx hold.
- IDLE output == (state == IDLE), registered with the state.
- Reset values: state IDLE, IDLE = 1, valid_out = 0, data_out = 0, grant_idx = 0, RR pointer = 4; popN = 0 while reset is high.

## Timing
- pop latency: popN is combinational from state, emptyN, stall and pointer; same cycle.
- Data latency: 1 cycle from popN high to valid_out/data_out.
- Start-up: the first pop occurs no earlier than 1 cycle after a FIFO becomes non-empty (IDLE -> ACTIVE edge).
- Sustained throughput: one word per cycle while any FIFO is non-empty and stall == 0.
- stall asserted mid-burst: pops stop the same cycle; valid_out drops on the next edge.
- FIFO going empty in the same cycle it is popped: the pop is honoured; next-cycle selection uses the new flags.
- reset asserted mid-operation: pops drop immediately; outputs take reset values asynchronously; any in-flight word is discarded.

## Configuration
- ROUND_ROBIN_EN defined: round-robin arbitration. A 3-bit pointer holds the last granted index; the search starts at pointer+1 mod 5 and wraps 4 -> 0; the pointer updates only on an issued pop.
- ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no pointer register.

## Test plan
- Reset check: hold reset high with all emptyN = 0 -> pop0..4 = 0, IDLE = 1, valid_out = 0, data_out = 0.
- Single FIFO: empty2 = 0 only, data_in2 = 6'h15 -> IDLE falls after 1 cycle; pop2 high next cycle; next edge: data_out = 6'h15, grant_idx = 2, valid_out = 1.
- All non-empty, 10 cycles, ROUND_ROBIN_EN defined -> grant order 0,1,2,3,4,0,1,2,3,4. Undefined -> pop0 every cycle.
- Stall: stall = 1 for 3 cycles during a burst -> no popN during those cycles; valid_out = 0 one cycle later; data_out unchanged; pops resume the cycle stall falls.
- Drain: FIFOs run empty -> state returns to IDLE and IDLE = 1 one edge after all emptyN = 1; pop counts per FIFO match the words supplied.
- Mid-burst reset: assert reset asynchronously between edges -> valid_out = 0 and pops = 0 immediately; after release the RR order restarts at FIFO 0.
